// File: rtl/another_struct_builder.sv
// another_struct_builder: folds DONE-terminated hero-bus bursts into another_struct records
// and queues them in a small output FIFO drained through a valid/ready port.
// Optional build macro: ANOTHER_STRUCT_BUILDER_TIMEOUT_EN adds an idle timeout that
// force-closes an open record with fieldc=IDLE after TIMEOUT_CYC quiet cycles.

package test_pkg_a;
    localparam int HERO_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        DONE  = 2'd2
    } CYCLE_TYPE_E;

    typedef struct packed {
        logic        wr_en;
        logic [3:0]  byte_en;
        logic [10:0] addr;
    } hero_write;
endpackage

package test_pkg_b;
    localparam int NEW_PARAM = 5;

    typedef struct packed {
        logic [test_pkg_a::HERO_WIDTH-1:0] fielda;
        test_pkg_a::hero_write             fieldb;
        test_pkg_a::CYCLE_TYPE_E           fieldc;
        logic [NEW_PARAM-1:0]              fieldd;
    } another_struct;
endpackage

module another_struct_builder #(
    parameter int FIFO_DEPTH = 4
`ifdef ANOTHER_STRUCT_BUILDER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = 64
`endif
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  test_pkg_a::CYCLE_TYPE_E               in_cycle,
    input  logic [test_pkg_a::HERO_WIDTH-1:0]     in_data,
    input  test_pkg_a::hero_write                 in_write,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output test_pkg_b::another_struct             out_rec,
    output logic [$clog2(FIFO_DEPTH):0]           rec_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NP    = test_pkg_b::NEW_PARAM;
    localparam int DW    = test_pkg_a::HERO_WIDTH;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [NP-1:0]    SAT_C   = NP'(31);

    typedef enum logic {
        EMPTY = 1'b0,
        OPEN  = 1'b1
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [DW-1:0]             acc_a;
    logic [DW-1:0]             acc_a_next;
    test_pkg_a::hero_write     acc_b;
    test_pkg_a::hero_write     acc_b_next;
    logic [NP-1:0]             acc_d;
    logic [NP-1:0]             acc_d_next;

    logic                      beat;
    logic                      counted;
    logic                      push;
    logic                      pop;
    test_pkg_b::another_struct push_rec;
    logic                      timeout_hit;

    test_pkg_b::another_struct mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [CNT_W-1:0]          cnt;
    logic [CNT_W-1:0]          cnt_next;
    logic                      ready_q;

    assign beat      = in_valid & ready_q;
    assign counted   = beat & ((in_cycle == test_pkg_a::VALID) || (in_cycle == test_pkg_a::DONE));
    assign out_valid = (cnt != '0);
    assign pop       = out_valid & out_ready;
    assign in_ready  = ready_q;
    assign rec_cnt   = cnt;
    assign out_rec   = out_valid ? mem[rd_ptr] : '0;

`ifdef ANOTHER_STRUCT_BUILDER_TIMEOUT_EN
    localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TMR_W-1:0] tmr;

    assign timeout_hit = (state == OPEN) && !beat && (tmr == TMR_W'(TIMEOUT_CYC - 1));

    // Idle timer: counts quiet cycles while a record is open, holds at the limit while full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr <= '0;
        end else if (beat || state_next == EMPTY) begin
            tmr <= '0;
        end else if (state == OPEN && !timeout_hit) begin
            tmr <= tmr + TMR_W'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // Next-state and accumulator update; builds the record to push when a burst closes.
    always_comb begin
        state_next = state;
        acc_a_next = acc_a;
        acc_b_next = acc_b;
        acc_d_next = acc_d;
        push       = 1'b0;
        push_rec   = '0;

        if (counted) begin
            if (state == EMPTY) begin
                acc_a_next = in_data;
                acc_b_next = in_write;
                acc_d_next = NP'(1);
            end else begin
                acc_a_next = acc_a ^ in_data;
                acc_d_next = acc_d + NP'(1);
            end
            state_next = OPEN;
            push_rec.fielda = acc_a_next;
            push_rec.fieldb = acc_b_next;
            push_rec.fieldd = acc_d_next;
            if (in_cycle == test_pkg_a::DONE) begin
                push            = 1'b1;
                push_rec.fieldc = test_pkg_a::DONE;
                state_next      = EMPTY;
            end else if (acc_d_next == SAT_C) begin
                push            = 1'b1;
                push_rec.fieldc = test_pkg_a::VALID;
                state_next      = EMPTY;
            end
        end else if (timeout_hit && ready_q) begin
            push            = 1'b1;
            push_rec.fielda = acc_a;
            push_rec.fieldb = acc_b;
            push_rec.fieldd = acc_d;
            push_rec.fieldc = test_pkg_a::IDLE;
            state_next      = EMPTY;
        end
    end

    // State and accumulator registers; reset drops any partially built record.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            acc_a <= '0;
            acc_b <= '0;
            acc_d <= '0;
        end else begin
            state <= state_next;
            acc_a <= acc_a_next;
            acc_b <= acc_b_next;
            acc_d <= acc_d_next;
        end
    end

    // Occupancy after this cycle's push/pop; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        cnt_next = cnt;
        unique case ({push, pop})
            2'b10:   cnt_next = cnt + CNT_W'(1);
            2'b01:   cnt_next = cnt - CNT_W'(1);
            default: cnt_next = cnt;
        endcase
    end

    // Record FIFO storage and pointers; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_rec;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            cnt <= cnt_next;
        end
    end

    // Registered not-full flag; computed from the next count so a full FIFO never overflows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= (cnt_next < DEPTH_C);
        end
    end

endmodule

// File: tb/tb_another_struct_builder.sv
// tb_another_struct_builder: directed self-checking bench for another_struct_builder.
// Build with ANOTHER_STRUCT_BUILDER_TIMEOUT_EN to add the idle-timeout scenario.
module tb_another_struct_builder;
    import test_pkg_a::*;
    import test_pkg_b::*;

    logic                   clk;
    logic                   rst;
    logic                   in_valid;
    logic                   in_ready;
    CYCLE_TYPE_E            in_cycle;
    logic [HERO_WIDTH-1:0]  in_data;
    hero_write              in_write;
    logic                   out_valid;
    logic                   out_ready;
    another_struct          out_rec;
    logic [2:0]             rec_cnt;

    int total_checks  = 0;
    int passed_checks = 0;
    int failed_checks = 0;

    localparam hero_write WA = hero_write'(16'h8123);
    localparam hero_write WB = hero_write'(16'h4456);
    localparam hero_write WC = hero_write'(16'hF789);

    another_struct_builder #(
        .FIFO_DEPTH(4)
`ifdef ANOTHER_STRUCT_BUILDER_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(8)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_cycle(in_cycle),
        .in_data(in_data),
        .in_write(in_write),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_rec(out_rec),
        .rec_cnt(rec_cnt)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else begin
            failed_checks++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Present one beat at the falling edge and hold it until it is accepted (bounded).
    task automatic applyStimulus(input CYCLE_TYPE_E c, input logic [HERO_WIDTH-1:0] d, input hero_write w);
        int waited;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_cycle = c;
        in_data  = d;
        in_write = w;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_cycle = IDLE;
        in_data  = '0;
    endtask

    // Wait (bounded) for a head record, check every field, then pop it.
    task automatic expectRecord(input string tag, input logic [HERO_WIDTH-1:0] a, input hero_write b,
                                input CYCLE_TYPE_E c, input logic [4:0] d);
        int waited;
        waited = 0;
        while (!out_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput({tag, "_valid"}, 64'(out_valid), 64'd1);
        checkOutput({tag, "_fielda"}, 64'(out_rec.fielda), 64'(a));
        checkOutput({tag, "_fieldb"}, 64'(out_rec.fieldb), 64'(b));
        checkOutput({tag, "_fieldc"}, 64'(out_rec.fieldc), 64'(c));
        checkOutput({tag, "_fieldd"}, 64'(out_rec.fieldd), 64'(d));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    // Directed scenario sequence.
    initial begin
        logic [HERO_WIDTH-1:0] drain_exp [5];
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_cycle  = IDLE;
        in_data   = '0;
        in_write  = '0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_rec_cnt", 64'(rec_cnt), 64'd0);
        checkOutput("rst_out_rec", 64'(out_rec), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rel_in_ready", 64'(in_ready), 64'd1);

        $display("[TB] three-beat burst");
        applyStimulus(VALID, 16'h0011, WA);
        applyStimulus(VALID, 16'h0022, WB);
        applyStimulus(DONE, 16'h0044, WC);
        checkOutput("burst_latency_valid", 64'(out_valid), 64'd1);
        checkOutput("burst_rec_cnt", 64'(rec_cnt), 64'd1);
        expectRecord("burst", 16'h0077, WA, DONE, 5'd3);
        checkOutput("burst_drained", 64'(rec_cnt), 64'd0);

        $display("[TB] single DONE from empty");
        applyStimulus(DONE, 16'h00A5, WB);
        expectRecord("single", 16'h00A5, WB, DONE, 5'd1);

        $display("[TB] saturation");
        for (int i = 0; i < 33; i++) begin
            applyStimulus(VALID, 16'h0001, (i == 0) ? WA : ((i == 31) ? WC : WB));
            if (i == 30) checkOutput("sat_close_cnt", 64'(rec_cnt), 64'd1);
        end
        applyStimulus(DONE, 16'h0001, WB);
        checkOutput("sat_two_records", 64'(rec_cnt), 64'd2);
        expectRecord("sat_rec1", 16'h0001, WA, VALID, 5'd31);
        expectRecord("sat_rec2", 16'h0001, WC, DONE, 5'd3);

        $display("[TB] backpressure with full FIFO");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(DONE, 16'h0010 + 16'(i), WA);
        end
        checkOutput("full_rec_cnt", 64'(rec_cnt), 64'd4);
        checkOutput("full_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        in_valid = 1'b1;
        in_cycle = DONE;
        in_data  = 16'h0014;
        in_write = WB;
        repeat (3) @(negedge clk);
        checkOutput("held_in_ready", 64'(in_ready), 64'd0);
        checkOutput("held_rec_cnt", 64'(rec_cnt), 64'd4);
        drain_exp[0] = 16'h0010;
        drain_exp[1] = 16'h0011;
        drain_exp[2] = 16'h0012;
        drain_exp[3] = 16'h0013;
        drain_exp[4] = 16'h0014;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("drain%0d_valid", i), 64'(out_valid), 64'd1);
            checkOutput($sformatf("drain%0d_fielda", i), 64'(out_rec.fielda), 64'(drain_exp[i]));
            if (i == 1) checkOutput("drain_reopen_ready", 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            if (i == 1) begin
                in_valid = 1'b0;
                in_cycle = IDLE;
                in_data  = '0;
            end
        end
        out_ready = 1'b0;
        checkOutput("drain_empty_valid", 64'(out_valid), 64'd0);
        checkOutput("drain_empty_cnt", 64'(rec_cnt), 64'd0);

        $display("[TB] IDLE beats interleaved");
        applyStimulus(IDLE, 16'h0099, WC);
        checkOutput("idle_no_record", 64'(rec_cnt), 64'd0);
        applyStimulus(VALID, 16'h0003, WB);
        applyStimulus(IDLE, 16'h0055, WA);
        applyStimulus(IDLE, 16'h00AA, WA);
        applyStimulus(DONE, 16'h000C, WC);
        expectRecord("idle_mix", 16'h000F, WB, DONE, 5'd2);

        $display("[TB] reset mid-record and mid-drain");
        applyStimulus(DONE, 16'h0066, WA);
        applyStimulus(VALID, 16'h0021, WA);
        applyStimulus(VALID, 16'h0042, WB);
        @(negedge clk);
        rst = 1'b1;
        #2;
        checkOutput("midrst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("midrst_rec_cnt", 64'(rec_cnt), 64'd0);
        checkOutput("midrst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("postrst_out_valid", 64'(out_valid), 64'd0);
        applyStimulus(DONE, 16'h0007, WC);
        expectRecord("postrst", 16'h0007, WC, DONE, 5'd1);

`ifdef ANOTHER_STRUCT_BUILDER_TIMEOUT_EN
        $display("[TB] idle timeout");
        applyStimulus(VALID, 16'h0005, WA);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("tmo_not_early", 64'(out_valid), 64'd0);
        repeat (6) @(posedge clk);
        #1;
        expectRecord("timeout", 16'h0005, WA, IDLE, 5'd1);
`endif

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
